// File: rtl/buff_sched_pkg.sv
// Shared constants, FSM encoding and free-buffer search for the buffer allocation scheduler.
package buff_sched_pkg;

  localparam int unsigned NUM_BUFF = 4;
  localparam int unsigned SLOTS    = 4;
  localparam int unsigned SLOT_W   = 2;
  localparam int unsigned BUFF_W   = 2;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_FULL   = 1'b1
  } state_t;

  // Lowest-index buffer whose full flag is clear (0 when none is free).
  function automatic logic [BUFF_W-1:0] first_free(input logic [NUM_BUFF-1:0] full);
    logic [BUFF_W-1:0] idx;
    idx = '0;
    for (int b = NUM_BUFF - 1; b >= 0; b--) begin
      if (!full[b]) idx = BUFF_W'(b);
    end
    return idx;
  endfunction

endpackage

// File: rtl/buff_alloc_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request scanning upward from rr_ptr with wrap.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   winner
);

  localparam int unsigned POS_W = PTR_W + 1;

  logic [POS_W-1:0] pos;
  logic             found;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // rr_ptr + k stays below 2*NUM_REQ, so one subtraction wraps it.
      pos = {1'b0, rr_ptr} + POS_W'(k);
      if (pos >= POS_W'(NUM_REQ)) pos = pos - POS_W'(NUM_REQ);
      if (enable && !found && req[pos[PTR_W-1:0]]) begin
        found                = 1'b1;
        winner               = pos[PTR_W-1:0];
        gnt[pos[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buff_alloc_scheduler.sv
// Allocates demux-selected buffers to round-robin requesters and tracks per-buffer slot counts
// so each grant reports the buffer and slot Demux_SEL is steering to.
module buff_alloc_scheduler
  import buff_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [BUFF_W-1:0]   gnt_buff,
  output logic [SLOT_W-1:0]   gnt_slot,
  output logic [NUM_BUFF-1:0] buff_use,
  output logic [NUM_BUFF-1:0] buff_full,
  input  logic [NUM_BUFF-1:0] drain,
  output logic                all_full
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  state_t                          state, state_next;
  logic [NUM_BUFF-1:0][CNT_W-1:0]  cnt, cnt_next;
  logic [NUM_BUFF-1:0]             full_next;
  logic [PTR_W-1:0]                rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0]                winner;
  logic [BUFF_W-1:0]               tgt;
  logic                            arb_en;
  logic                            transfer;

  // Grants only in ACTIVE with a free buffer; rst gates them low during reset.
  assign tgt    = first_free(buff_full);
  assign arb_en = rst && (state == ST_ACTIVE) && !(&buff_full);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .enable (arb_en),
    .gnt    (gnt),
    .winner (winner)
  );

  assign transfer = |gnt;
  assign gnt_buff = tgt;
  assign gnt_slot = cnt[tgt][SLOT_W-1:0];
  assign buff_use = transfer ? (NUM_BUFF'(1) << tgt) : '0;

  // Next counts, full flags, arbitration pointer and FSM state.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    full_next   = '0;
    rr_ptr_next = rr_ptr;

    for (int unsigned b = 0; b < NUM_BUFF; b++) begin
      if (drain[b] && buff_full[b]) begin
        cnt_next[b] = '0;
      end else if (transfer && (tgt == BUFF_W'(b))) begin
        cnt_next[b] = cnt[b] + CNT_W'(1);
      end
      full_next[b] = (cnt_next[b] == CNT_W'(SLOTS));
    end

    if (transfer) begin
      rr_ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
    end

    case (state)
      ST_ACTIVE: if (&full_next) state_next = ST_FULL;
      ST_FULL:   if (|(drain & buff_full)) state_next = ST_ACTIVE;
      default:   state_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ACTIVE;
      cnt       <= '0;
      buff_full <= '0;
      all_full  <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      buff_full <= full_next;
      all_full  <= (state_next == ST_FULL);
      rr_ptr    <= rr_ptr_next;
    end
  end

endmodule
